// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Optional feature macro used by the design: RESET_SEQ_TIMEOUT_EN.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        WAIT    = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    // Counter must hold the larger of the hold interval and the ready-wait limit.
    function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
        int longest;
        longest = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rst_sync_2ff.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clk edge.
// Output rst_s is active-low (high once the board reset has been released and synchronised).
module rst_sync_2ff (
    input  logic clk,
    input  logic async_reset,
    output logic rst_s
);

    logic meta;

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            meta  <= 1'b0;
            rst_s <= 1'b0;
        end else begin
            meta  <= 1'b1;
            rst_s <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered release of NUM_DOMAINS reset domains from one board reset, with soft re-run.
// Define RESET_SEQ_TIMEOUT_EN to bound each domain's ready wait to TIMEOUT_CYCLES.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   async_reset_i,
    input  logic                   soft_reset_i,
    input  logic [NUM_DOMAINS-1:0] domain_ready_i,
    output logic [NUM_DOMAINS-1:0] domain_reset_o,
    output logic                   busy_o,
    output logic                   seq_done_o,
    output logic                   timeout_err_o
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    logic                   rst_s;
    seq_state_t             state;
    seq_state_t             state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_nxt;
    logic [NUM_DOMAINS-1:0] domain_reset_nxt;
    logic                   busy_nxt;
    logic                   seq_done_nxt;
    logic                   ready_cur;
    logic                   advance;

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic timeout_err_q;
    logic timeout_err_nxt;
`endif

    rst_sync_2ff u_rst_sync (
        .clk         (clk),
        .async_reset (async_reset_i),
        .rst_s       (rst_s)
    );

    assign ready_cur = domain_ready_i[idx];

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        idx_nxt          = idx;
        domain_reset_nxt = domain_reset_o;
        advance          = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
        timeout_err_nxt  = timeout_err_q;
`endif

        // A soft request overrides everything, including a ready seen on the same edge.
        if (soft_reset_i) begin
            state_nxt        = ASSERT;
            cnt_nxt          = '0;
            idx_nxt          = '0;
            domain_reset_nxt = '1;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_err_nxt  = 1'b0;
`endif
        end else begin
            case (state)
                ASSERT: begin
                    if (cnt == HOLD_LAST) begin
                        state_nxt = RELEASE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    domain_reset_nxt[idx] = 1'b0;
                    cnt_nxt               = '0;
                    state_nxt             = WAIT;
                end
                WAIT: begin
                    if (ready_cur) begin
                        advance = 1'b1;
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        advance         = 1'b1;
                        timeout_err_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
`endif
                    if (advance) begin
                        if (idx == IDX_LAST) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt   = idx + 1'b1;
                            state_nxt = RELEASE;
                        end
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
            endcase
        end

        busy_nxt     = (state_nxt != DONE);
        seq_done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            state          <= ASSERT;
            cnt            <= '0;
            idx            <= '0;
            domain_reset_o <= '1;
            busy_o         <= 1'b1;
            seq_done_o     <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            idx            <= idx_nxt;
            domain_reset_o <= domain_reset_nxt;
            busy_o         <= busy_nxt;
            seq_done_o     <= seq_done_nxt;
`ifdef RESET_SEQ_TIMEOUT_EN
            timeout_err_q  <= timeout_err_nxt;
`endif
        end
    end

`ifdef RESET_SEQ_TIMEOUT_EN
    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule
